dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port 1024x32 data memory between two requesters: port 0 (core load/store unit) and port 1 (loader/DMA/debug).
- Per-cycle valid/grant handshake with round-robin tie-break and a burst-ownership limit.
- Drives the RAM's address, write-enable and write-data pins; captures the combinational read data into a registered response.
- Sits between the datapath/loader and the data memory instance.

Parameters:
- ADDR_W, 10, word address width (1024 locations).
- DATA_W, 32, data width.
- MAX_BURST, 4, max consecutive grants to one port while the other is requesting; legal range 1..15.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  port 0 access request.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_addr  in  ADDR_W  port 0 word address.
- m0_wdata  in  DATA_W  port 0 write data.
- m0_gnt  out  1  port 0 access performed this cycle.
- m0_rvalid  out  1  port 0 read data valid on rsp_rdata.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid: same as port 0, for port 1.
- rsp_rdata  out  DATA_W  registered read data, shared by both ports.
- mem_addr  out  ADDR_W  to RAM address.
- mem_we  out  1  to RAM write enable.
- mem_wdata  out  DATA_W  to RAM write data.
- mem_rdata  in  DATA_W  RAM combinational read data.

Behaviour:
- States: IDLE, OWN0, OWN1. Registers: state, burst_cnt (4b), rr_last (last port served), rsp_rdata, m0_rvalid, m1_rvalid.
- Reset: state=IDLE, burst_cnt=0, rr_last=1 (port 0 wins the first tie), rsp_rdata=0, rvalid=0. While rst=1: gnt=0 and mem_we=0.
- Grant (combinational, same cycle as req):
  - Owner (OWNx) keeps the grant if req_x=1 and (burst_cnt<MAX_BURST or req of the other port=0).
  - Otherwise grant the other port if it requests.
  - In IDLE with both requesting: grant port !rr_last. With one requesting: grant it.
  - At most one gnt high per cycle.
- Next state: OWNx if port x granted; IDLE if no grant. A port that drops req loses ownership immediately.
- burst_cnt: set to 1 on a grant to a port different from the previous cycle's grantee or after IDLE; increment on a repeat grant, saturating at MAX_BURST. rr_last is updated to the granted port.
- Handoff timing: an owner at MAX_BURST with the other port idle keeps the grant. The cycle the other port asserts req, it is granted.
- Memory drive:
  - mem_addr = granted port's addr; when no grant, mem_addr holds port 0's addr.
  - mem_wdata = granted port's wdata.
  - mem_we = gnt & we; the write commits at that rising edge.
- Read latency 1: a read granted in cycle N gives rsp_rdata=mem_rdata captured at the end of N, with mx_rvalid=1 in cycle N+1 only.
  - rsp_rdata holds its value when there is no new read.
  - Writes never raise rvalid.
- Same-address read following a write in the previous cycle returns the new data.
- Reset asserted mid-operation: a read granted in the reset cycle produces no rvalid; state returns to IDLE.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined: adds outputs m0_wait_cnt[31:0] and m1_wait_cnt[31:0].
  - Each increments every cycle its req=1 and gnt=0.
  - Saturates at 0xFFFFFFFF; cleared by rst.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package dmem_arb_pkg: state enum (IDLE/OWN0/OWN1), port-ID constants P0=0 and P1=1, default ADDR_W/DATA_W.
- One sub-module, dmem_arb_wait_cnt: saturating wait counter, instantiated per port under DMEM_ARB_PERF_EN.
- Grant logic stays inline.

Test Plan:
- Reset, then m0 reads addr 28 (RAM holds 0x20): m0_gnt same cycle; next cycle m0_rvalid=1, rsp_rdata=0x00000020, m1_rvalid=0.
- Both request from IDLE after reset: m0 granted first. m1 granted after m0 has held the grant for 4 consecutive cycles (MAX_BURST=4); m0 is granted again after m1's 4.
- m1 alone requests for 10 cycles: m1_gnt held all 10 cycles; m0 then asserts req: m0_gnt that same cycle.
- m0 writes 0xDEADBEEF to addr 40, then m1 reads addr 40 the next cycle: rsp_rdata=0xDEADBEEF with m1_rvalid.
- rst asserted in the cycle a read is granted: no rvalid follows; state IDLE; mem_we=0 throughout reset.
- DMEM_ARB_PERF_EN defined, m1 blocked 4 cycles by an m0 burst: m1_wait_cnt=4, m0_wait_cnt=0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/dmem_arb_wait_cnt.sv
// Saturating 32-bit wait-cycle counter; counts cycles with inc=1, cleared by rst.
module dmem_arb_wait_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] cnt
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with burst limit in front of a single-port 1024x32 RAM.
// DMEM_ARB_PERF_EN adds per-port saturating wait-cycle counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       m0_wait_cnt,
  output logic [31:0]       m1_wait_cnt
`endif
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  arb_state_e        state_q, state_d;
  logic [3:0]        burst_cnt_q, burst_cnt_d;
  logic              rr_last_q, rr_last_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              m0_rvalid_q, m0_rvalid_d;
  logic              m1_rvalid_q, m1_rvalid_d;
  logic              gnt0, gnt1;

  // Owner keeps the port until it drops req or hits the burst limit with the other side waiting.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      OWN0: begin
        if (m0_req && ((burst_cnt_q < MAX_B) || !m1_req)) gnt0 = 1'b1;
        else if (m1_req)                                  gnt1 = 1'b1;
      end
      OWN1: begin
        if (m1_req && ((burst_cnt_q < MAX_B) || !m0_req)) gnt1 = 1'b1;
        else if (m0_req)                                  gnt0 = 1'b1;
      end
      default: begin
        if (m0_req && m1_req) begin
          gnt0 = (rr_last_q == P1);
          gnt1 = (rr_last_q == P0);
        end else begin
          gnt0 = m0_req;
          gnt1 = m1_req;
        end
      end
    endcase
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    state_d     = gnt0 ? OWN0 : (gnt1 ? OWN1 : IDLE);
    rr_last_d   = gnt0 ? P0 : (gnt1 ? P1 : rr_last_q);
    burst_cnt_d = 4'd0;
    if ((gnt0 && state_q == OWN0) || (gnt1 && state_q == OWN1))
      burst_cnt_d = (burst_cnt_q >= MAX_B) ? MAX_B : burst_cnt_q + 4'd1;
    else if (gnt0 || gnt1)
      burst_cnt_d = 4'd1;
    m0_rvalid_d = gnt0 && !m0_we;
    m1_rvalid_d = gnt1 && !m1_we;
    rsp_rdata_d = (m0_rvalid_d || m1_rvalid_d) ? mem_rdata : rsp_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      burst_cnt_q <= 4'd0;
      rr_last_q   <= P1;
      rsp_rdata_q <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      rr_last_q   <= rr_last_d;
      rsp_rdata_q <= rsp_rdata_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_addr  = gnt1 ? m1_addr  : m0_addr;
  assign mem_wdata = gnt1 ? m1_wdata : m0_wdata;
  assign mem_we    = (gnt0 && m0_we) || (gnt1 && m1_we);

`ifdef DMEM_ARB_PERF_EN
  dmem_arb_wait_cnt u_wait0 (.clk(clk), .rst(rst), .inc(m0_req && !gnt0), .cnt(m0_wait_cnt));
  dmem_arb_wait_cnt u_wait1 (.clk(clk), .rst(rst), .inc(m1_req && !gnt1), .cnt(m1_wait_cnt));
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic against a reference model.
module tb_dmem_arbiter;

  localparam int MAXB = 4;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [9:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] rsp_rdata;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] m0_wait_cnt, m1_wait_cnt;
`endif

  logic [31:0] ram     [1024];
  logic [31:0] ref_mem [1024];

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: owner (-1 = nobody), consecutive-grant count, last served port
  int          own = -1;
  int          cnt = 0;
  int          last = 1;
  logic        exp_rv0 = 1'b0, exp_rv1 = 1'b0;
  logic [31:0] exp_rsp = 32'h0;
  logic [31:0] exp_w0 = 32'h0, exp_w1 = 32'h0;

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .m0_wait_cnt(m0_wait_cnt), .m1_wait_cnt(m1_wait_cnt)
`endif
  );

  assign mem_rdata = ram[mem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Who gets the RAM this cycle, straight from the arbitration rules.
  function automatic int model_gnt();
    bit mine, other;
    if (rst) return -1;
    if (own >= 0) begin
      mine  = (own == 0) ? m0_req : m1_req;
      other = (own == 0) ? m1_req : m0_req;
      if (mine && (cnt < MAXB || !other)) return own;
      if (other) return 1 - own;
      return -1;
    end
    if (m0_req && m1_req) return 1 - last;
    if (m0_req) return 0;
    if (m1_req) return 1;
    return -1;
  endfunction

  task automatic model_update(input int g);
    logic        we;
    logic [9:0]  a;
    logic [31:0] d;
    if (rst) begin
      own = -1; cnt = 0; last = 1;
      exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rsp = 32'h0;
      exp_w0 = 32'h0; exp_w1 = 32'h0;
      return;
    end
    if (m0_req && g != 0 && exp_w0 != 32'hFFFF_FFFF) exp_w0++;
    if (m1_req && g != 1 && exp_w1 != 32'hFFFF_FFFF) exp_w1++;
    exp_rv0 = 1'b0;
    exp_rv1 = 1'b0;
    if (g >= 0) begin
      we = (g == 0) ? m0_we : m1_we;
      a  = (g == 0) ? m0_addr : m1_addr;
      d  = (g == 0) ? m0_wdata : m1_wdata;
      if (we) ref_mem[a] = d;
      else begin
        exp_rsp = ref_mem[a];
        if (g == 0) exp_rv0 = 1'b1; else exp_rv1 = 1'b1;
      end
      cnt  = (g == own) ? ((cnt + 1 > MAXB) ? MAXB : cnt + 1) : 1;
      last = g;
    end else begin
      cnt = 0;
    end
    own = g;
  endtask

  // Check the current cycle against the model, then clock it through RAM and model.
  task automatic cycle();
    int          g;
    logic        s_we;
    logic [9:0]  s_addr;
    logic [31:0] s_wdata;
    #2;
    g = model_gnt();
    chk("gnt0", {31'b0, m0_gnt}, {31'b0, g == 0});
    chk("gnt1", {31'b0, m1_gnt}, {31'b0, g == 1});
    chk("mem_we", {31'b0, mem_we},
        {31'b0, (g == 0 && m0_we) || (g == 1 && m1_we)});
    chk("mem_addr", {22'b0, mem_addr}, {22'b0, (g == 1) ? m1_addr : m0_addr});
    if (g >= 0) chk("mem_wdata", mem_wdata, (g == 1) ? m1_wdata : m0_wdata);
    chk("rvalid0", {31'b0, m0_rvalid}, {31'b0, exp_rv0});
    chk("rvalid1", {31'b0, m1_rvalid}, {31'b0, exp_rv1});
    chk("rsp_rdata", rsp_rdata, exp_rsp);
`ifdef DMEM_ARB_PERF_EN
    chk("wait0", m0_wait_cnt, exp_w0);
    chk("wait1", m1_wait_cnt, exp_w1);
`endif
    s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
    @(posedge clk);
    if (s_we) ram[s_addr] = s_wdata;
    model_update(g);
    #1;
  endtask

  task automatic drive(input bit r0, input bit w0, input int a0, input logic [31:0] d0,
                       input bit r1, input bit w1, input int a1, input logic [31:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = 10'(a0); m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = 10'(a1); m1_wdata = d1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    logic [31:0] gseq [12];
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = 32'(i + 4);
      ref_mem[i] = 32'(i + 4);
    end
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;
    cycle();

    // single read from addr 28, which holds 0x20
    drive(1, 0, 28, 32'h0, 0, 0, 0, 32'h0);
    #1 chk("t1_gnt", {31'b0, m0_gnt}, 32'd1);
    cycle();
    idle();
    #1;
    chk("t1_rvalid0", {31'b0, m0_rvalid}, 32'd1);
    chk("t1_rvalid1", {31'b0, m1_rvalid}, 32'd0);
    chk("t1_rdata", rsp_rdata, 32'h0000_0020);
    cycle();
    cycle();

    // contention from IDLE: port 0 first, then bursts of MAX_BURST alternate
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 100 + i, 32'h0, 1, 0, 200 + i, 32'h0);
      #1 gseq[i] = {30'b0, m1_gnt, m0_gnt};
      cycle();
    end
    chk("t2_first", gseq[0], 32'd1);
    chk("t2_m0_last", gseq[3], 32'd1);
    chk("t2_handoff", gseq[4], 32'd2);
    chk("t2_back", gseq[8], 32'd1);

    // port 1 alone past the burst limit, then port 0 arrives
    idle(); cycle();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 32'h0, 1, 0, 300 + i, 32'h0);
      #1 chk("t3_hold", {31'b0, m1_gnt}, 32'd1);
      cycle();
    end
    drive(1, 0, 5, 32'h0, 1, 0, 310, 32'h0);
    #1 chk("t3_m0_gnt", {31'b0, m0_gnt}, 32'd1);
    cycle();

    // write then read-after-write from the other port
    idle(); cycle();
    drive(1, 1, 40, 32'hDEAD_BEEF, 0, 0, 0, 32'h0);
    cycle();
    drive(0, 0, 0, 32'h0, 1, 0, 40, 32'h0);
    cycle();
    idle();
    #1;
    chk("t4_rvalid1", {31'b0, m1_rvalid}, 32'd1);
    chk("t4_rdata", rsp_rdata, 32'hDEAD_BEEF);
    cycle();

    // reset landing on a granted read, and on a write
    drive(1, 0, 7, 32'h0, 0, 0, 0, 32'h0);
    cycle();
    rst = 1'b1;
    drive(1, 0, 9, 32'h0, 1, 1, 11, 32'h1234_5678);
    #1;
    chk("t5_gnt0", {31'b0, m0_gnt}, 32'd0);
    chk("t5_we", {31'b0, mem_we}, 32'd0);
    cycle();
    rst = 1'b0;
    idle();
    #1;
    chk("t5_rv0", {31'b0, m0_rvalid}, 32'd0);
    chk("t5_rv1", {31'b0, m1_rvalid}, 32'd0);
    cycle();

`ifdef DMEM_ARB_PERF_EN
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, i, 32'h0, 1, 0, 50 + i, 32'h0);
      cycle();
    end
    idle();
    #1;
    chk("t6_wait1", m1_wait_cnt, 32'd4);
    chk("t6_wait0", m0_wait_cnt, 32'd0);
    cycle();
`endif

    // random traffic on a small address window to provoke read-after-write
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, $urandom_range(0, 15), $urandom,
            $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, $urandom_range(0, 15), $urandom);
      cycle();
    end
    rst = 1'b0;
    idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
